program_loader: RTL and testbench

Boot-time sequencer that loads the instruction image into program memory over the UART byte stream before the pipeline starts.
- On `start` it sends sync byte 0x99, then receives a 4-byte little-endian program size in bytes.
- It then receives the program bytes, packs them into 32-bit words and writes them to program memory.
- Finally it sends ack byte 0xAA.
- Sits between the UART rx/tx byte engines and program memory; the top-level state controller consumes its completion pulses.

---
 rtl/loader_pkg.sv | 7 +
 rtl/byte_word_packer.sv | 39 +++
 rtl/program_loader.sv | 126 ++++++++++++
 tb/tb_program_loader.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// loader_pkg: state encoding, handshake bytes and size width shared by the program loader.
package loader_pkg;
  typedef enum logic [2:0] {S_IDLE, S_TX_SYNC, S_RX_SIZE, S_RX_DATA, S_TX_ACK, S_DONE, S_ERROR} state_e;
  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'h99;
  localparam logic [7:0] ACK_BYTE_DEFAULT = 8'hAA;
  localparam int SIZE_W = 32;
endpackage

// File: rtl/byte_word_packer.sv
// byte_word_packer: packs a little-endian byte stream into 32-bit words, flushing early on the last byte.
module byte_word_packer (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        clear_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  input  logic        flush_i,
  output logic        word_valid_o,
  output logic [31:0] word_o
);
  logic [1:0] lane_q, lane_d;
  logic [31:0] asm_q, asm_d, word_q, word_d, merged;
  logic valid_q, valid_d, emit;
  assign merged = asm_q | (32'(byte_i) << {lane_q, 3'b000});
  assign emit = byte_valid_i && (lane_q == 2'd3 || flush_i);
  // Assembly clears in the emitting cycle so a byte in the following write cycle lands in lane 0.
  always_comb begin
    lane_d = clear_i ? 2'd0 : emit ? 2'd0 : byte_valid_i ? lane_q + 2'd1 : lane_q;
    asm_d = (clear_i || emit) ? 32'd0 : byte_valid_i ? merged : asm_q;
    word_d = emit ? merged : 32'd0;
    valid_d = emit;
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      lane_q <= 2'd0;
      asm_q <= 32'd0;
      word_q <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      lane_q <= lane_d;
      asm_q <= asm_d;
      word_q <= word_d;
      valid_q <= valid_d;
    end
  end
  assign word_valid_o = valid_q;
  assign word_o = word_q;
endmodule

// File: rtl/program_loader.sv
// program_loader: boot sequencer that requests, receives and writes the program image over the UART byte stream.
module program_loader import loader_pkg::*; #(
  parameter int PROGRAM_MEMORY_ADDRESS_BITWIDTH = 12,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT,
  parameter logic [7:0] ACK_BYTE = ACK_BYTE_DEFAULT
) (
  input  logic                                       clk_i,
  input  logic                                       reset_i,
  input  logic                                       start_i,
  input  logic                                       rx_valid_i,
  input  logic [7:0]                                 rx_data_i,
  input  logic                                       tx_ready_i,
  output logic                                       tx_valid_o,
  output logic [7:0]                                 tx_data_o,
  output logic                                       program_memory_write_enable_o,
  output logic [PROGRAM_MEMORY_ADDRESS_BITWIDTH-1:0] program_memory_write_address_o,
  output logic [31:0]                                program_memory_write_data_o,
  output logic                                       sync_sent_o,
  output logic                                       size_received_o,
  output logic                                       program_received_o,
  output logic                                       ack_sent_o,
  output logic                                       busy_o,
  output logic                                       done_o,
  output logic                                       error_o
);
  localparam int W = PROGRAM_MEMORY_ADDRESS_BITWIDTH;
  localparam logic [SIZE_W:0] CAP = (SIZE_W+1)'(4) << W;
  state_e state_q, state_d;
  logic [SIZE_W-1:0] size_q, size_d, cnt_q, cnt_d, size_nx;
  logic [1:0] scnt_q, scnt_d;
  logic [W-1:0] addr_q, addr_d;
  logic sync_q, sync_d, szr_q, szr_d, prg_q, prg_d, ack_q, ack_d;
  logic idle_like, restart, rx_byte, last, word_valid;
  logic [31:0] word;
  assign idle_like = state_q == S_IDLE || state_q == S_DONE || state_q == S_ERROR;
  assign restart = start_i && idle_like;
  assign rx_byte = rx_valid_i && state_q == S_RX_DATA;
  assign last = cnt_q == size_q - 1'b1;
  assign size_nx = {rx_data_i, size_q[SIZE_W-1:8]};
  byte_word_packer u_packer (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .clear_i      (restart),
    .byte_valid_i (rx_byte),
    .byte_i       (rx_data_i),
    .flush_i      (last),
    .word_valid_o (word_valid),
    .word_o       (word)
  );
  always_comb begin
    state_d = state_q;
    size_d = size_q;
    cnt_d = cnt_q;
    scnt_d = scnt_q;
    addr_d = word_valid ? addr_q + 1'b1 : addr_q;
    sync_d = 1'b0;
    szr_d = 1'b0;
    prg_d = 1'b0;
    ack_d = 1'b0;
    if (restart) begin
      state_d = S_TX_SYNC;
      size_d = '0;
      cnt_d = '0;
      scnt_d = 2'd0;
      addr_d = '0;
    end else case (state_q)
      S_TX_SYNC: if (tx_ready_i) begin
        state_d = S_RX_SIZE;
        sync_d = 1'b1;
      end
      S_RX_SIZE: if (rx_valid_i) begin
        size_d = size_nx;
        scnt_d = scnt_q + 2'd1;
        if (scnt_q == 2'd3) begin
          szr_d = 1'b1;
          state_d = {1'b0, size_nx} > CAP ? S_ERROR : size_nx == '0 ? S_TX_ACK : S_RX_DATA;
        end
      end
      S_RX_DATA: if (rx_valid_i) begin
        cnt_d = cnt_q + 1'b1;
        prg_d = last;
        state_d = last ? S_TX_ACK : S_RX_DATA;
      end
      S_TX_ACK: if (tx_ready_i) begin
        state_d = S_DONE;
        ack_d = 1'b1;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      size_q <= '0;
      cnt_q <= '0;
      scnt_q <= 2'd0;
      addr_q <= '0;
      sync_q <= 1'b0;
      szr_q <= 1'b0;
      prg_q <= 1'b0;
      ack_q <= 1'b0;
    end else begin
      state_q <= state_d;
      size_q <= size_d;
      cnt_q <= cnt_d;
      scnt_q <= scnt_d;
      addr_q <= addr_d;
      sync_q <= sync_d;
      szr_q <= szr_d;
      prg_q <= prg_d;
      ack_q <= ack_d;
    end
  end
  assign tx_valid_o = state_q == S_TX_SYNC || state_q == S_TX_ACK;
  assign tx_data_o = state_q == S_TX_SYNC ? SYNC_BYTE : state_q == S_TX_ACK ? ACK_BYTE : 8'h00;
  assign program_memory_write_enable_o = word_valid;
  assign program_memory_write_address_o = word_valid ? addr_q : '0;
  assign program_memory_write_data_o = word;
  assign sync_sent_o = sync_q;
  assign size_received_o = szr_q;
  assign program_received_o = prg_q;
  assign ack_sent_o = ack_q;
  assign busy_o = !idle_like;
  assign done_o = state_q == S_DONE;
  assign error_o = state_q == S_ERROR;
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: randomized and directed loads checked against a byte-stream reference model.
module tb_program_loader;
  localparam int W = 4;
  logic clk = 1'b0;
  logic reset, start, rx_valid, tx_ready;
  logic [7:0] rx_data;
  logic tx_valid, we, sync_sent, size_received, program_received, ack_sent, busy, done, error;
  logic [7:0] tx_data;
  logic [W-1:0] waddr;
  logic [31:0] wdata;
  int checks = 0, passed = 0;
  logic [W-1:0] wr_addr[$];
  logic [31:0] wr_data[$];
  logic [7:0] tx_bytes[$];
  int prog_at[$];
  int n_sync = 0, n_size = 0, n_ack = 0;
  int b_wr, b_tx, b_sync, b_size, b_prog, b_ack;

  always #5 clk = ~clk;

  program_loader #(.PROGRAM_MEMORY_ADDRESS_BITWIDTH(W)) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .rx_valid_i(rx_valid), .rx_data_i(rx_data),
    .tx_ready_i(tx_ready), .tx_valid_o(tx_valid), .tx_data_o(tx_data),
    .program_memory_write_enable_o(we), .program_memory_write_address_o(waddr),
    .program_memory_write_data_o(wdata), .sync_sent_o(sync_sent), .size_received_o(size_received),
    .program_received_o(program_received), .ack_sent_o(ack_sent), .busy_o(busy), .done_o(done),
    .error_o(error)
  );

  always @(negedge clk) begin
    if (we) begin
      wr_addr.push_back(waddr);
      wr_data.push_back(wdata);
    end
    if (tx_valid && tx_ready) tx_bytes.push_back(tx_data);
    if (program_received) prog_at.push_back(we ? int'(waddr) : -1);
    if (sync_sent) n_sync++;
    if (size_received) n_size++;
    if (ack_sent) n_ack++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic snap;
    b_wr = wr_data.size(); b_tx = tx_bytes.size(); b_sync = n_sync;
    b_size = n_size; b_prog = prog_at.size(); b_ack = n_ack;
  endtask

  // Pulse deltas since snap, one decimal digit each: sync, size, program, ack.
  function automatic int pulses();
    return (n_sync - b_sync) * 1000 + (n_size - b_size) * 100 + (prog_at.size() - b_prog) * 10 + (n_ack - b_ack);
  endfunction

  // Reference: byte k lands in word k/4 at byte lane k%4; missing upper lanes stay zero.
  function automatic void model(input logic [7:0] b[$], input int size, output logic [31:0] w[$]);
    w = {};
    for (int k = 0; k < size; k++) begin
      if (k % 4 == 0) w.push_back(32'd0);
      w[k / 4] = w[k / 4] + (32'(b[k]) << (8 * (k % 4)));
    end
  endfunction

  function automatic void size_bytes(input logic [31:0] s, output logic [7:0] q[$]);
    q = '{s[7:0], s[15:8], s[23:16], s[31:24]};
  endfunction

  task automatic send_bytes(input logic [7:0] q[$], input int gap_max);
    foreach (q[i]) begin
      rx_valid = 1'b1;
      rx_data = q[i];
      tick;
      rx_valid = 1'b0;
      repeat ($urandom_range(gap_max, 0)) tick;
    end
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  task automatic wait_sync(output bit to);
    to = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (sync_sent) begin
        to = 1'b0;
        return;
      end
    end
  endtask

  task automatic wait_end(output bit to);
    to = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (done || error) begin
        to = 1'b0;
        tick;
        return;
      end
      tick;
    end
  endtask

  task automatic run_load(input logic [7:0] d[$], input int size, input int gap, output bit to);
    logic [7:0] sb[$];
    bit t1, t2;
    size_bytes(size, sb);
    pulse_start;
    wait_sync(t1);
    send_bytes(sb, 0);
    send_bytes(d, gap);
    wait_end(t2);
    to = t1 | t2;
  endtask

  task automatic test_reset;
    repeat (3) tick;
    checks++;
    if ({tx_valid, tx_data, we, waddr, wdata, sync_sent, size_received, program_received, ack_sent, busy, done, error} !== '0)
      $display("FAIL reset_outputs: got tx_valid=%b busy=%b done=%b error=%b we=%b, want all 0", tx_valid, busy, done, error, we);
    else passed++;
    reset = 1'b0;
    repeat (2) tick;
    checks++;
    if ({tx_valid, busy, done, error, we} !== 5'b0)
      $display("FAIL reset_idle: got tx_valid=%b busy=%b done=%b error=%b we=%b, want all 0", tx_valid, busy, done, error, we);
    else passed++;
  endtask

  task automatic test_basic;
    logic [7:0] d[$];
    bit to;
    d = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    snap;
    run_load(d, 8, 1, to);
    checks++;
    if (to || wr_data.size() - b_wr != 2) $display("FAIL basic_count: timeout=%0d writes=%0d, want 0 and 2", to, wr_data.size() - b_wr);
    else passed++;
    checks++;
    if (wr_data[b_wr] !== 32'h00000013 || wr_addr[b_wr] !== 0 || wr_data[b_wr+1] !== 32'h00100093 || wr_addr[b_wr+1] !== 1)
      $display("FAIL basic_words: got %h@%0d %h@%0d, want 00000013@0 00100093@1", wr_data[b_wr], wr_addr[b_wr], wr_data[b_wr+1], wr_addr[b_wr+1]);
    else passed++;
    checks++;
    if (tx_bytes.size() - b_tx != 2 || tx_bytes[b_tx] !== 8'h99 || tx_bytes[b_tx+1] !== 8'hAA)
      $display("FAIL basic_tx: got %0d bytes first %h second %h, want 2 bytes 99 aa", tx_bytes.size() - b_tx, tx_bytes[b_tx], tx_bytes[b_tx+1]);
    else passed++;
    checks++;
    if (pulses() != 1111 || prog_at[prog_at.size()-1] != 1)
      $display("FAIL basic_pulses: got %0d prog_at=%0d, want 1111 prog_at=1", pulses(), prog_at[prog_at.size()-1]);
    else passed++;
    checks++;
    if ({done, busy, error} !== 3'b100) $display("FAIL basic_done: got done=%b busy=%b error=%b, want 1 0 0", done, busy, error);
    else passed++;
  endtask

  task automatic test_partial;
    logic [7:0] d[$];
    bit to;
    d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    snap;
    run_load(d, 6, 2, to);
    checks++;
    if (to || wr_data.size() - b_wr != 2) $display("FAIL partial_count: timeout=%0d writes=%0d, want 0 and 2", to, wr_data.size() - b_wr);
    else passed++;
    checks++;
    if (wr_data[b_wr] !== 32'h44332211 || wr_data[b_wr+1] !== 32'h00006655 || wr_addr[b_wr+1] !== 1)
      $display("FAIL partial_words: got %h %h@%0d, want 44332211 00006655@1", wr_data[b_wr], wr_data[b_wr+1], wr_addr[b_wr+1]);
    else passed++;
  endtask

  task automatic test_oversize;
    logic [7:0] d[$];
    bit to;
    d = {};
    snap;
    run_load(d, 32'h44, 0, to);
    checks++;
    if (to || {error, done, tx_valid, busy} !== 4'b1000)
      $display("FAIL oversize_state: timeout=%0d error=%b done=%b tx_valid=%b busy=%b, want 0 1 0 0 0", to, error, done, tx_valid, busy);
    else passed++;
    checks++;
    if (pulses() != 1100 || tx_bytes.size() - b_tx != 1) $display("FAIL oversize_pulses: got %0d tx=%0d, want 1100 tx=1", pulses(), tx_bytes.size() - b_tx);
    else passed++;
    send_bytes('{8'h01, 8'h02, 8'h03, 8'h04}, 0);
    tick;
    checks++;
    if (wr_data.size() != b_wr || error !== 1'b1) $display("FAIL oversize_writes: got writes=%0d error=%b, want 0 and 1", wr_data.size() - b_wr, error);
    else passed++;
  endtask

  task automatic test_zero;
    logic [7:0] d[$];
    bit to;
    d = {};
    snap;
    run_load(d, 0, 0, to);
    checks++;
    if (to || wr_data.size() != b_wr || pulses() != 1101 || {done, error} !== 2'b10)
      $display("FAIL zero_size: timeout=%0d writes=%0d pulses=%0d done=%b error=%b, want 0 0 1101 1 0", to, wr_data.size() - b_wr, pulses(), done, error);
    else passed++;
    checks++;
    if (tx_bytes.size() - b_tx != 2 || tx_bytes[b_tx+1] !== 8'hAA) $display("FAIL zero_tx: got %0d bytes last %h, want 2 aa", tx_bytes.size() - b_tx, tx_bytes[tx_bytes.size()-1]);
    else passed++;
  endtask

  task automatic load_and_compare(input string name, input int size, input int gap);
    logic [7:0] d[$];
    logic [31:0] e[$];
    bit to;
    int bad;
    d = {};
    repeat (size) d.push_back(8'($urandom));
    model(d, size, e);
    snap;
    run_load(d, size, gap, to);
    checks++;
    if (to || wr_data.size() - b_wr != (size + 3) / 4 || pulses() != 1111 || done !== 1'b1)
      $display("FAIL %s_count: size=%0d timeout=%0d writes=%0d pulses=%0d done=%b, want 0 %0d 1111 1", name, size, to, wr_data.size() - b_wr, pulses(), done, (size + 3) / 4);
    else passed++;
    bad = 0;
    for (int i = 0; i < e.size(); i++)
      if (wr_data[b_wr+i] !== e[i] || int'(wr_addr[b_wr+i]) != i) begin
        if (bad == 0) $display("FAIL %s_word%0d: got %h@%0d, want %h@%0d", name, i, wr_data[b_wr+i], wr_addr[b_wr+i], e[i], i);
        bad++;
      end
    checks++;
    if (bad == 0) passed++;
  endtask

  task automatic test_back_to_back;
    logic [7:0] d[$], q[$];
    logic [31:0] e[$];
    bit to, held;
    d = {};
    repeat (8) d.push_back(8'($urandom));
    model(d, 8, e);
    size_bytes(8, q);
    q = {q, d};
    snap;
    pulse_start;
    wait_sync(to);
    tx_ready = 1'b0;
    send_bytes(q, 0);
    held = 1'b1;
    repeat (5) begin
      held &= tx_valid === 1'b1 && tx_data === 8'hAA && n_ack == b_ack;
      tick;
    end
    checks++;
    if (!held) $display("FAIL b2b_hold: got tx_valid=%b tx_data=%h acks=%0d, want 1 aa 0", tx_valid, tx_data, n_ack - b_ack);
    else passed++;
    tx_ready = 1'b1;
    begin
      bit t2;
      wait_end(t2);
      to |= t2;
    end
    checks++;
    if (to || wr_data.size() - b_wr != 2 || wr_data[b_wr] !== e[0] || wr_data[b_wr+1] !== e[1])
      $display("FAIL b2b_words: timeout=%0d writes=%0d got %h %h, want %h %h", to, wr_data.size() - b_wr, wr_data[b_wr], wr_data[b_wr+1], e[0], e[1]);
    else passed++;
    checks++;
    if (pulses() != 1111 || tx_bytes.size() - b_tx != 2) $display("FAIL b2b_ack: got pulses=%0d tx=%0d, want 1111 2", pulses(), tx_bytes.size() - b_tx);
    else passed++;
  endtask

  task automatic test_reset_mid_load;
    logic [7:0] d[$];
    bit to;
    snap;
    pulse_start;
    wait_sync(to);
    send_bytes('{8'h08, 8'h00, 8'h00, 8'h00, 8'hA1, 8'hA2, 8'hA3}, 1);
    reset = 1'b1;
    tick;
    checks++;
    if (to || wr_data.size() != b_wr || {tx_valid, we, wdata, program_received, busy, done, error} !== '0)
      $display("FAIL midreset_outputs: timeout=%0d writes=%0d busy=%b we=%b, want 0 0 0 0", to, wr_data.size() - b_wr, busy, we);
    else passed++;
    reset = 1'b0;
    tick;
    d = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    snap;
    run_load(d, 4, 0, to);
    checks++;
    if (to || wr_data.size() - b_wr != 1 || wr_data[b_wr] !== 32'hEFBEADDE || wr_addr[b_wr] !== 0)
      $display("FAIL midreset_reload: timeout=%0d writes=%0d got %h@%0d, want 1 efbeadde@0", to, wr_data.size() - b_wr, wr_data[b_wr], wr_addr[b_wr]);
    else passed++;
  endtask

  task automatic test_ignored;
    logic [7:0] q[$];
    bit to, t2;
    snap;
    tx_ready = 1'b0;
    pulse_start;
    send_bytes('{8'h55, 8'h66, 8'h77}, 0);
    checks++;
    if ({tx_valid, busy} !== 2'b11 || tx_data !== 8'h99 || n_size != b_size)
      $display("FAIL ignored_txsync: got tx_valid=%b busy=%b tx_data=%h, want 1 1 99", tx_valid, busy, tx_data);
    else passed++;
    tx_ready = 1'b1;
    wait_sync(to);
    size_bytes(4, q);
    send_bytes(q, 0);
    send_bytes('{8'h10, 8'h20}, 0);
    pulse_start;
    send_bytes('{8'h30, 8'h40}, 0);
    wait_end(t2);
    checks++;
    if (to || t2 || wr_data.size() - b_wr != 1 || wr_data[b_wr] !== 32'h40302010 || pulses() != 1111)
      $display("FAIL ignored_rxdata: timeout=%0d writes=%0d got %h pulses=%0d, want 1 40302010 1111", to | t2, wr_data.size() - b_wr, wr_data[b_wr], pulses());
    else passed++;
    snap;
    send_bytes('{8'h01, 8'h02, 8'h03}, 1);
    tick;
    checks++;
    if (wr_data.size() != b_wr || {done, busy, tx_valid} !== 3'b100)
      $display("FAIL ignored_done: writes=%0d done=%b busy=%b tx_valid=%b, want 0 1 0 0", wr_data.size() - b_wr, done, busy, tx_valid);
    else passed++;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b1;
    test_reset;
    test_basic;
    test_partial;
    test_oversize;
    test_zero;
    load_and_compare("full", 64, 1);
    test_back_to_back;
    test_reset_mid_load;
    test_ignored;
    for (int i = 0; i < 5; i++) load_and_compare("random", $urandom_range(64, 1), $urandom_range(2, 0));
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
